// File: rtl/wb_commit_arbiter.sv
// Writeback commit arbiter: A/B pipe results own write ports 1/2, and queued mul/div (L) results
// drain in order into whichever ports the pipes leave idle.
module wb_commit_arbiter #(
    parameter int ADDR_SIZE = 5,
    parameter int DEPTH     = 4,
    parameter int DW        = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      a_valid,
    input  logic [ADDR_SIZE-1:0]      a_addr,
    input  logic [DW-1:0]             a_data,
    input  logic                      b_valid,
    input  logic [ADDR_SIZE-1:0]      b_addr,
    input  logic [DW-1:0]             b_data,
    input  logic                      l_valid,
    output logic                      l_ready,
    input  logic [ADDR_SIZE-1:0]      l_addr,
    input  logic [DW-1:0]             l_data,
    output logic                      W1E,
    output logic [ADDR_SIZE-1:0]      WAddr1,
    output logic [DW-1:0]             WData1,
    output logic                      W2E,
    output logic [ADDR_SIZE-1:0]      WAddr2,
    output logic [DW-1:0]             WData2,
    output logic [2**ADDR_SIZE-1:0]   pend_mask,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]           r_wr_ptr;
    logic [PW:0]           r_rd_ptr;
    logic [ADDR_SIZE-1:0]  r_addr_mem [DEPTH];
    logic [DW-1:0]         r_data_mem [DEPTH];
    logic [DEPTH-1:0]      r_valid;

    logic                  w_a_wr;
    logic                  w_b_wr;
    logic                  w_a_eff;
    logic                  w_l_fire;
    logic [PW:0]           w_count;
    logic [PW-1:0]         w_head_idx;
    logic [PW-1:0]         w_next_idx;
    logic [PW-1:0]         w_wr_idx;
    logic [1:0]            w_n_pop;
    logic [DEPTH-1:0]      w_resident;
    logic [DEPTH-1:0]      w_popped;
    logic [DEPTH-1:0]      w_squash;
    logic [DEPTH-1:0]      w_valid_next;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_head_idx = r_rd_ptr[PW-1:0];
    assign w_next_idx = w_head_idx + PW'(1);
    assign w_wr_idx   = r_wr_ptr[PW-1:0];
    assign fifo_count = w_count;
    assign l_ready    = (w_count != (PW+1)'(DEPTH));
    assign w_l_fire   = l_valid & l_ready;

    assign w_a_wr  = a_valid & (a_addr != '0);
    assign w_b_wr  = b_valid & (b_addr != '0);
    // B is program-younger, so on a same-address collision only B's value may land.
    assign w_a_eff = w_a_wr & ~(w_b_wr & (a_addr == b_addr));

    // Port 1 belongs to A, port 2 to B; the FIFO head fills the lowest idle port.
    always_comb begin
        W1E     = 1'b0;
        WAddr1  = a_addr;
        WData1  = a_data;
        W2E     = 1'b0;
        WAddr2  = b_addr;
        WData2  = b_data;
        w_n_pop = 2'd0;
        if (w_a_eff) begin
            W1E = 1'b1;
        end else if (w_count != '0) begin
            W1E     = r_valid[w_head_idx];
            WAddr1  = r_addr_mem[w_head_idx];
            WData1  = r_data_mem[w_head_idx];
            w_n_pop = 2'd1;
        end
        if (w_b_wr) begin
            W2E = 1'b1;
        end else if (w_a_eff) begin
            if (w_count != '0) begin
                W2E     = r_valid[w_head_idx];
                WAddr2  = r_addr_mem[w_head_idx];
                WData2  = r_data_mem[w_head_idx];
                w_n_pop = 2'd1;
            end
        end else if (w_count > (PW+1)'(1)) begin
            W2E     = r_valid[w_next_idx];
            WAddr2  = r_addr_mem[w_next_idx];
            WData2  = r_data_mem[w_next_idx];
            w_n_pop = 2'd2;
        end
        if (RST) begin
            W1E = 1'b0;
            W2E = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_slot
            logic [PW-1:0] w_off;
            assign w_off          = PW'(gi) - w_head_idx;
            assign w_resident[gi] = ({1'b0, w_off} < w_count);
            assign w_popped[gi]   = ({1'b0, w_off} < (PW+1)'(w_n_pop));
            assign w_squash[gi]   = (w_a_wr & (r_addr_mem[gi] == a_addr)) |
                                    (w_b_wr & (r_addr_mem[gi] == b_addr));
            // A newer pipe write to the same register makes a waiting L result stale.
            assign w_valid_next[gi] = (w_l_fire && (w_wr_idx == PW'(gi))) ? (l_addr != '0) :
                                      (r_valid[gi] & ~(w_resident[gi] & ~w_popped[gi] & w_squash[gi]));
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + (PW+1)'(w_l_fire);
            r_rd_ptr <= r_rd_ptr + (PW+1)'(w_n_pop);
            r_valid  <= w_valid_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_l_fire) begin
            r_addr_mem[w_wr_idx] <= l_addr;
            r_data_mem[w_wr_idx] <= l_data;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_resident[i] && r_valid[i]) pend_mask[r_addr_mem[i]] = 1'b1;
        end
    end
endmodule
